uart_rx: RTL and testbench

- Serial byte receiver for the host-to-FPGA control link (8N1, LSB first, idle-high line).
- Sits between the external RX pin and the frame/colour parser. It delivers each received byte over a valid/ready handshake.
- It flags framing errors and overruns as single-cycle status pulses, usable directly as debug LED strobes.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and FSM
// state encodings. The transmitter imports the same package.
package uart_rx_pkg;

    // Data bits per 8N1 frame.
    localparam int unsigned UART_DATA_BITS = 8;

    // 12 MHz board clock at 115200 baud.
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 104;

    // Receiver FSM states, 3-bit encodings.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
// RESET_VAL sets both flops on reset so an idle-high line reads idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx             raw serial input (asynchronous)
//   data, valid    received byte and holding-register-full flag
//   ready          consumer accepts data when valid & ready
//   frame_err      one-cycle pulse, stop bit sampled low
//   overrun        one-cycle pulse, byte completed with holding register full
//   busy           receiver FSM not idle
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DW    = UART_DATA_BITS;
    localparam int unsigned IDX_W = 3;

    // Start bit is checked at mid-bit; every later sample is one full period on.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DW - 1);

    logic rxs;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;
    logic [DW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    // Line synchroniser, reset to the idle level.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rxs)
    );

    // Frame FSM: next state, bit timing, shift register and frame status.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // A line already high again at mid-bit was a glitch.
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[DW-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Held-low break: wait for the line to recover before rearming.
                cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Holding register and valid/ready handshake, fed by the completion strobe.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (done_q) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit (clock period 10).
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int          BIT_T = 160;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Event monitor, sampled on the falling edge.
    int         vrise_cnt  = 0;
    logic [7:0] vrise_data = 8'h00;
    int         ferr_cyc   = 0;
    int         ovr_cyc    = 0;
    logic [7:0] ovr_data   = 8'h00;
    logic       valid_prev = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1 && valid_prev !== 1'b1) begin
            vrise_cnt++;
            vrise_data = data;
        end
        valid_prev = valid;
        if (frame_err === 1'b1) ferr_cyc++;
        if (overrun === 1'b1) begin
            ovr_cyc++;
            ovr_data = data;
        end
    end

    task automatic clr_mon();
        vrise_cnt = 0;
        ferr_cyc  = 0;
        ovr_cyc   = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_bit;
        #(bit_t);
    endtask

    task automatic test_reset();
        idle(3);
        vec_cnt++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_values: data=%h valid=%b ferr=%b ovr=%b busy=%b, want 00 0 0 0 0",
                     data, valid, frame_err, overrun, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int         n;
        logic [7:0] d_at;
        n     = 0;
        d_at  = 8'h00;
        ready = 1'b1;
        clr_mon();
        @(posedge clk);
        #1;
        fork
            send_byte(8'hA5, 1'b1, BIT_T);
            begin
                while (valid !== 1'b1 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                d_at = data;
            end
        join
        vec_cnt++;
        if (n < 152 || n > 156) begin
            err_cnt++;
            $display("FAIL basic_latency: valid after %0d cycles, want 152..156", n);
        end
        vec_cnt++;
        if (d_at !== 8'hA5) begin
            err_cnt++;
            $display("FAIL basic_data: data=%h, want a5", d_at);
        end
        idle(10);
        vec_cnt++;
        if (vrise_cnt != 1 || ferr_cyc != 0 || ovr_cyc != 0 || valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_pulses: vrise=%0d ferr=%0d ovr=%0d valid=%b, want 1 0 0 0",
                     vrise_cnt, ferr_cyc, ovr_cyc, valid);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        clr_mon();
        @(posedge clk);
        #1;
        send_byte(8'h3C, 1'b1, BIT_T);
        send_byte(8'h81, 1'b1, BIT_T);
        idle(8);
        vec_cnt++;
        if (vrise_cnt != 1 || vrise_data !== 8'h3C) begin
            err_cnt++;
            $display("FAIL b2b_first: vrise=%0d data=%h, want 1 3c", vrise_cnt, vrise_data);
        end
        vec_cnt++;
        if (ovr_cyc != 1 || ovr_data !== 8'h3C) begin
            err_cnt++;
            $display("FAIL b2b_overrun: ovr_cycles=%0d data_at_ovr=%h, want 1 3c", ovr_cyc, ovr_data);
        end
        vec_cnt++;
        if (valid !== 1'b1 || data !== 8'h3C || ferr_cyc != 0) begin
            err_cnt++;
            $display("FAIL b2b_held: valid=%b data=%h ferr=%0d, want 1 3c 0", valid, data, ferr_cyc);
        end
        ready = 1'b1;
        idle(1);
        vec_cnt++;
        if (valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_consume: valid=%b, want 0", valid);
        end
    endtask

    task automatic test_frame_err();
        ready = 1'b1;
        clr_mon();
        @(posedge clk);
        #1;
        send_byte(8'h55, 1'b0, BIT_T);
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(20);
        vec_cnt++;
        if (ferr_cyc != 1 || vrise_cnt != 0 || ovr_cyc != 0) begin
            err_cnt++;
            $display("FAIL ferr_break: ferr=%0d vrise=%0d ovr=%0d, want 1 0 0", ferr_cyc, vrise_cnt, ovr_cyc);
        end
        send_byte(8'h12, 1'b1, BIT_T);
        idle(8);
        vec_cnt++;
        if (vrise_cnt != 1 || vrise_data !== 8'h12 || ferr_cyc != 1) begin
            err_cnt++;
            $display("FAIL ferr_recover: vrise=%0d data=%h ferr=%0d, want 1 12 1",
                     vrise_cnt, vrise_data, ferr_cyc);
        end
    endtask

    task automatic test_glitch();
        clr_mon();
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(1);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL glitch_busy_high: busy=%b, want 1", busy);
        end
        idle(7);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL glitch_busy_low: busy=%b, want 0", busy);
        end
        idle(200);
        vec_cnt++;
        if (vrise_cnt != 0 || ferr_cyc != 0 || ovr_cyc != 0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL glitch_quiet: vrise=%0d ferr=%0d ovr=%0d busy=%b, want 0 0 0 0",
                     vrise_cnt, ferr_cyc, ovr_cyc, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b     = 8'hF0;
        ready = 1'b0;
        clr_mon();
        @(posedge clk);
        #1;
        send_byte(8'h11, 1'b1, BIT_T);
        idle(5);
        vec_cnt++;
        if (valid !== 1'b1 || data !== 8'h11) begin
            err_cnt++;
            $display("FAIL rstmid_hold: valid=%b data=%h, want 1 11", valid, data);
        end
        // Partial 0xF0 frame, cut off halfway through bit 4.
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_T);
        end
        rx = b[4];
        #(BIT_T / 2 + 3);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_busy: busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_async: data=%h valid=%b ferr=%b ovr=%b busy=%b, want 00 0 0 0 0",
                     data, valid, frame_err, overrun, busy);
        end
        rx = 1'b1;
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        ready = 1'b1;
        clr_mon();
        send_byte(8'h0F, 1'b1, BIT_T);
        idle(8);
        vec_cnt++;
        if (vrise_cnt != 1 || vrise_data !== 8'h0F || ferr_cyc != 0 || ovr_cyc != 0) begin
            err_cnt++;
            $display("FAIL rstmid_recover: vrise=%0d data=%h ferr=%0d ovr=%0d, want 1 0f 0 0",
                     vrise_cnt, vrise_data, ferr_cyc, ovr_cyc);
        end
    endtask

    task automatic test_skew();
        int periods[2];
        periods[0] = 165;
        periods[1] = 155;
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle(20);
            clr_mon();
            send_byte(8'h6B, 1'b1, periods[k]);
            idle(10);
            vec_cnt++;
            if (vrise_cnt != 1 || vrise_data !== 8'h6B || ferr_cyc != 0) begin
                err_cnt++;
                $display("FAIL skew_%0d: vrise=%0d data=%h ferr=%0d, want 1 6b 0",
                         periods[k], vrise_cnt, vrise_data, ferr_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        idle(20);
        test_frame_err();
        idle(20);
        test_glitch();
        test_reset_mid();
        test_skew();
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
